// File: rtl/hs_arb_pkg.sv
// Shared state type and limits for the hiscore / CPU work-RAM arbiter.
package hs_arb_pkg;

  typedef enum logic [2:0] {IDLE, REQ, SETTLE, GRANT, REL} hs_arb_state_t;

  localparam int unsigned RD_LAT_MAX = 3;

endpackage

// File: rtl/hs_ram_arbiter.sv
// Shares the single-port CPU work RAM between the Z80 and the hiscore engine via a pause handshake.
// Optional pause-ack timeout with sticky error flag is built when HSARB_TIMEOUT_EN is defined.
module hs_ram_arbiter #(
  parameter int unsigned AW     = 12,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned SETTLE = 4
`ifdef HSARB_TIMEOUT_EN
  ,
  parameter int unsigned TMO_CYC = 4096
`endif
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_we,
  input  logic [AW-1:0] hs_address,
  input  logic [DW-1:0] hs_data_in,
  input  logic          hs_write_enable,
  input  logic          hs_access_read,
  input  logic          hs_access_write,
  input  logic          cpu_paused,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  output logic          hs_pause,
  output logic          hs_grant,
  output logic          hs_rd_valid,
  output logic          hs_error
);

  import hs_arb_pkg::*;

  localparam int unsigned RL     = (RD_LAT < 1) ? 1 :
                                   ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
  localparam int unsigned SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned SET_LD = (SETTLE > 0) ? SETTLE - 1 : 0;

  hs_arb_state_t state_q;
  logic          pause_q;
  logic          grant_q;
  logic [SW-1:0] cnt_q;
  logic [RL-1:0] rdv_q;
  logic          intent;
  logic          start_c;
  logic          tmo_hit_c;

  assign intent = hs_access_read | hs_access_write;

`ifdef HSARB_TIMEOUT_EN
  localparam int unsigned    TMO_W    = 12;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  logic             ign_q;

  // After a timeout the same intent level is ignored until it deasserts.
  assign start_c   = intent & ~ign_q;
  assign tmo_hit_c = (state_q == REQ) && intent && !cpu_paused && (tmo_q == TMO_LAST);
  assign hs_error  = err_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tmo_q <= '0;
      err_q <= 1'b0;
      ign_q <= 1'b0;
    end else begin
      if (state_q == REQ) tmo_q <= tmo_q + TMO_W'(1);
      else                tmo_q <= '0;
      if (tmo_hit_c) begin
        err_q <= 1'b1;
        ign_q <= 1'b1;
      end else if (!intent) begin
        ign_q <= 1'b0;
      end
    end
  end
`else
  assign start_c   = intent;
  assign tmo_hit_c = 1'b0;
  assign hs_error  = 1'b0;
`endif

  // Handshake FSM; pause, grant and read-valid are all registered here.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      pause_q <= 1'b0;
      grant_q <= 1'b0;
      cnt_q   <= '0;
      rdv_q   <= '0;
    end else begin
      rdv_q <= RL'({rdv_q, grant_q & hs_access_read});
      case (state_q)
        IDLE: begin
          if (start_c) begin
            state_q <= REQ;
            pause_q <= 1'b1;
          end
        end
        REQ: begin
          if (!intent || tmo_hit_c) begin
            state_q <= IDLE;
            pause_q <= 1'b0;
          end else if (cpu_paused) begin
            state_q <= hs_arb_pkg::SETTLE;
            cnt_q   <= SW'(SET_LD);
          end
        end
        hs_arb_pkg::SETTLE: begin
          if (!intent || !cpu_paused) begin
            state_q <= REL;
          end else if (cnt_q == '0) begin
            state_q <= GRANT;
            grant_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - SW'(1);
          end
        end
        GRANT: begin
          if (!intent || !cpu_paused) begin
            state_q <= REL;
            grant_q <= 1'b0;
            rdv_q   <= '0;
          end
        end
        REL: begin
          state_q <= IDLE;
          pause_q <= 1'b0;
          rdv_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          pause_q <= 1'b0;
          grant_q <= 1'b0;
        end
      endcase
    end
  end

  // Grant doubles as the registered mux select; a dropped ack kills any hiscore write that cycle.
  assign ram_addr    = grant_q ? hs_address : cpu_addr;
  assign ram_din     = grant_q ? hs_data_in : cpu_din;
  assign ram_we      = grant_q ? (hs_write_enable & cpu_paused) : cpu_we;
  assign hs_pause    = pause_q;
  assign hs_grant    = grant_q;
  assign hs_rd_valid = rdv_q[RL-1];

endmodule
